// File: rtl/apb3_pixel_fifo_slave.sv
// apb3_pixel_fifo_slave
//   APB3 slave that buffers a camera pixel stream in a FIFO and lets the CPU
//   drain it through a DATA register, with status, control, overflow tracking.
//   Optional level interrupt: compile with `define PIXFIFO_IRQ_EN to enable it;
//   without the macro the IRQ port is tied low and THRESH is storage only.
//
// Handshake semantics:
//   APB side: setup = PSEL & !PENABLE, access = PSEL & PENABLE; a transfer
//   completes in the access cycle where PREADY=1, PRDATA/PSLVERR are only
//   meaningful in that cycle and PRDATA is 0 otherwise.
//   Pixel side: a word transfers on every clock edge where PIX_VALID and
//   PIX_READY are both 1; PIX_READY never depends on PIX_VALID. A word offered
//   while enabled and full is dropped and counted as overflow.
module apb3_pixel_fifo_slave #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 8
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              PIX_VALID,
  input  logic [DATA_W-1:0] PIX_DATA,
  output logic              PIX_READY,
  output logic              IRQ,
  output logic [0:0]        dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Read-path states: idle, or holding a popped word for the second access cycle.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;

  localparam logic [ADDR_W-3:0] A_DATA   = (ADDR_W-2)'(0);
  localparam logic [ADDR_W-3:0] A_STATUS = (ADDR_W-2)'(1);
  localparam logic [ADDR_W-3:0] A_CTRL   = (ADDR_W-2)'(2);
  localparam logic [ADDR_W-3:0] A_THRESH = (ADDR_W-2)'(3);
  localparam logic [ADDR_W-3:0] A_OVFCNT = (ADDR_W-2)'(4);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              en;
  logic              ovf;
  logic [15:0]       ovf_cnt;
  logic [15:0]       thresh;
  logic [DATA_W-1:0] rd_data_q;
  logic [0:0]        state;

  logic              access;
  logic [ADDR_W-3:0] word_addr;
  logic              mapped;
  logic              empty;
  logic              full;
  logic              pop_commit;
  logic              clr_pending;
  logic              wr_ctrl;
  logic              wr_thresh;
  logic              push;
  logic              drop;
  logic              unused_bits;

  assign access      = PSEL & PENABLE;
  assign word_addr   = PADDR[ADDR_W-1:2];
  assign mapped      = (word_addr <= A_OVFCNT);
  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign wr_ctrl     = access & PWRITE & (word_addr == A_CTRL);
  assign wr_thresh   = access & PWRITE & (word_addr == A_THRESH);
  assign clr_pending = wr_ctrl & PWDATA[1];
  // The pop is decided from the current empty flag, so a same-cycle push cannot rescue it.
  assign pop_commit  = !PRESET & access & !PWRITE & (word_addr == A_DATA)
                       & (state == ST_IDLE) & !empty;
  assign PIX_READY   = !PRESET & en & !full & !clr_pending;
  assign push        = PIX_VALID & PIX_READY;
  assign drop        = PIX_VALID & en & full;
  assign dbg_state   = state;
  assign unused_bits = ^{PWDATA[31:16], PADDR[1:0]};

  // APB response: zero-wait for everything except a non-empty DATA read.
  always_comb begin
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    PRDATA  = 32'd0;
    if (!PRESET && access) begin
      if (state == ST_DATA) begin
        PRDATA = 32'(rd_data_q);
      end else if (!mapped) begin
        PSLVERR = 1'b1;
      end else if (!PWRITE) begin
        case (word_addr)
          A_DATA: begin
            if (empty) PSLVERR = 1'b1;
            else       PREADY  = 1'b0;
          end
          A_STATUS: PRDATA = {13'd0, ovf, full, empty, 16'(count)};
          A_CTRL:   PRDATA = {31'd0, en};
          A_THRESH: PRDATA = {16'd0, thresh};
          A_OVFCNT: PRDATA = {16'd0, ovf_cnt};
          default:  PRDATA = 32'd0;
        endcase
      end
    end
  end

  // Pointers, occupancy, control registers, overflow tracking and read staging.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      en        <= 1'b0;
      ovf       <= 1'b0;
      ovf_cnt   <= 16'd0;
      thresh    <= 16'd0;
      rd_data_q <= '0;
      state     <= ST_IDLE;
    end else begin
      state <= pop_commit ? ST_DATA : ST_IDLE;
      if (pop_commit) rd_data_q <= mem[rd_ptr];
      if (wr_ctrl)    en        <= PWDATA[0];
      if (wr_thresh)  thresh    <= PWDATA[15:0];
      if (clr_pending) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        ovf     <= 1'b0;
        ovf_cnt <= 16'd0;
      end else begin
        if (push)       wr_ptr <= wr_ptr + PW'(1);
        if (pop_commit) rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop_commit)      count <= count + CW'(1);
        else if (!push && pop_commit) count <= count - CW'(1);
        if (drop) begin
          ovf <= 1'b1;
          if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
        end
      end
    end
  end

  // FIFO storage write; contents need no reset since occupancy guards reads.
  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= PIX_DATA;
  end

`ifdef PIXFIFO_IRQ_EN
  logic irq_q;

  // Registered level interrupt: enabled, threshold programmed, and occupancy reached.
  always_ff @(posedge PCLK) begin
    if (PRESET) irq_q <= 1'b0;
    else        irq_q <= en & (16'(count) >= thresh) & (thresh != 16'd0);
  end

  assign IRQ = irq_q;
`else
  assign IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_apb3_pixel_fifo_slave.sv
// tb_apb3_pixel_fifo_slave
//   Directed bench for apb3_pixel_fifo_slave with a queue-based reference model
//   checked every cycle, plus literal expectations on register reads.
//   Honours `define PIXFIFO_IRQ_EN to match the DUT build.
module tb_apb3_pixel_fifo_slave;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 8;

  // ---------------- clock / reset ----------------
  logic              PCLK = 1'b0;
  logic              PRESET = 1'b1;
  logic              PSEL = 1'b0;
  logic              PENABLE = 1'b0;
  logic              PWRITE = 1'b0;
  logic [ADDR_W-1:0] PADDR = '0;
  logic [31:0]       PWDATA = '0;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic              PIX_VALID = 1'b0;
  logic [DATA_W-1:0] PIX_DATA = '0;
  logic              PIX_READY;
  logic              IRQ;
  logic [0:0]        dbg_state;

  always #5 PCLK = ~PCLK;

  apb3_pixel_fifo_slave #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .PIX_VALID(PIX_VALID), .PIX_DATA(PIX_DATA), .PIX_READY(PIX_READY), .IRQ(IRQ),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_fifo[$];
  logic              m_en = 1'b0;
  logic              m_ovf = 1'b0;
  logic              m_irq = 1'b0;
  logic              m_second = 1'b0;
  int                m_ovfcnt = 0;
  logic [15:0]       m_thresh = 16'd0;
  logic [DATA_W-1:0] m_word = '0;

  task automatic model_step();
    logic acc, full, empty, clr_wr, pop, e_ready, e_err, e_pix, e_irq, en_now;
    logic [31:0] e_rdata;
    int idx, n;
    acc    = PSEL && PENABLE;
    idx    = int'(PADDR) >> 2;
    n      = m_fifo.size();
    full   = (n == DEPTH);
    empty  = (n == 0);
    en_now = m_en;
    clr_wr = acc && PWRITE && idx == 2 && PWDATA[1];
    e_ready = 1'b1; e_err = 1'b0; e_rdata = 32'd0; pop = 1'b0;
    if (!PRESET && acc) begin
      if (m_second) e_rdata = 32'(m_word);
      else if (idx > 4) e_err = 1'b1;
      else if (!PWRITE) begin
        case (idx)
          0: if (empty) e_err = 1'b1; else begin e_ready = 1'b0; pop = 1'b1; end
          1: e_rdata = 32'(n) | (32'(empty) << 16) | (32'(full) << 17) | (32'(m_ovf) << 18);
          2: e_rdata = 32'(m_en);
          3: e_rdata = 32'(m_thresh);
          default: e_rdata = 32'(m_ovfcnt);
        endcase
      end
    end
    e_pix = !PRESET && m_en && !full && !clr_wr;
`ifdef PIXFIFO_IRQ_EN
    e_irq = m_irq;
`else
    e_irq = 1'b0;
`endif
    check("cyc PREADY", 32'(PREADY), 32'(e_ready));
    check("cyc PSLVERR", 32'(PSLVERR), 32'(e_err));
    check("cyc PRDATA", PRDATA, e_rdata);
    check("cyc PIX_READY", 32'(PIX_READY), 32'(e_pix));
    check("cyc IRQ", 32'(IRQ), 32'(e_irq));
    if (PRESET) begin
      m_fifo.delete(); m_en = 1'b0; m_ovf = 1'b0; m_ovfcnt = 0;
      m_thresh = 16'd0; m_irq = 1'b0; m_second = 1'b0;
    end else begin
      m_irq = en_now && (n >= int'(m_thresh)) && (m_thresh != 16'd0);
      if (pop) m_word = m_fifo[0];
      m_second = pop;
      if (acc && PWRITE && idx == 2) m_en = PWDATA[0];
      if (acc && PWRITE && idx == 3) m_thresh = PWDATA[15:0];
      if (clr_wr) begin
        m_fifo.delete(); m_ovf = 1'b0; m_ovfcnt = 0;
      end else begin
        if (pop) void'(m_fifo.pop_front());
        if (PIX_VALID && e_pix) m_fifo.push_back(PIX_DATA);
        if (PIX_VALID && en_now && full) begin
          m_ovf = 1'b1;
          if (m_ovfcnt < 65535) m_ovfcnt++;
        end
      end
    end
  endtask

  // Compare process: starts once reset has been seen at a clock edge.
  initial begin : compare_proc
    do @(posedge PCLK); while (!PRESET);
    forever begin
      @(negedge PCLK);
      model_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int waits);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0;
    @(negedge PCLK);
    while (!PREADY && waits < 16) begin
      waits++;
      @(negedge PCLK);
    end
    rd = PRDATA; err = PSLVERR;
    if (!PREADY) check("apb completion timeout", 32'(PREADY), 32'd1);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] ed, input logic ee,
                    input int ew, input string name);
    logic [31:0] d; logic e; int w;
    apb_xfer(1'b0, a, 32'd0, d, e, w);
    check({name, " data"}, d, ed);
    check({name, " err"}, 32'(e), 32'(ee));
    check({name, " waits"}, 32'(w), 32'(ew));
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] wd, input logic ee, input string name);
    logic [31:0] d; logic e; int w;
    apb_xfer(1'b1, a, wd, d, e, w);
    check({name, " err"}, 32'(e), 32'(ee));
    check({name, " waits"}, 32'(w), 32'd0);
  endtask

  // Offer a word until accepted; accepted words go into the expected queue.
  task automatic push_word(input logic [31:0] d);
    int guard = 0;
    @(posedge PCLK); #1;
    PIX_VALID = 1'b1; PIX_DATA = d;
    @(negedge PCLK);
    while (!PIX_READY && guard < 500) begin
      guard++;
      @(negedge PCLK);
    end
    if (PIX_READY) exp_q.push_back(d);
    else check("push timeout", 32'(PIX_READY), 32'd1);
    @(posedge PCLK); #1;
    PIX_VALID = 1'b0;
  endtask

  // Offer a word for exactly one cycle, accepted or not.
  task automatic offer_word(input logic [31:0] d);
    @(posedge PCLK); #1;
    PIX_VALID = 1'b1; PIX_DATA = d;
    @(posedge PCLK); #1;
    PIX_VALID = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: bench did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin : main
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;

    // 1: reset state
    @(negedge PCLK);
    check("t1 PIX_READY after reset", 32'(PIX_READY), 32'd0);
    rd(8'h04, 32'h0001_0000, 1'b0, 0, "t1 STATUS");
    rd(8'h00, 32'd0, 1'b1, 0, "t1 empty DATA");
    rd(8'h08, 32'd0, 1'b0, 0, "t1 CTRL");

    // 2: three words in, three out with one wait state each
    wr(8'h08, 32'd1, 1'b0, "t2 CTRL en");
    push_word(32'h11); push_word(32'h22); push_word(32'h33);
    rd(8'h04, 32'h0000_0003, 1'b0, 0, "t2 STATUS");
    rd(8'h00, 32'h11, 1'b0, 1, "t2 DATA0");
    rd(8'h00, 32'h22, 1'b0, 1, "t2 DATA1");
    rd(8'h00, 32'h33, 1'b0, 1, "t2 DATA2");
    rd(8'h04, 32'h0001_0000, 1'b0, 0, "t2 STATUS empty");

    // 3: fill, overflow by two, drain in order
    for (int i = 0; i < DEPTH; i++) push_word(32'(i));
    offer_word(32'hDEAD_0040);
    offer_word(32'hDEAD_0041);
    @(negedge PCLK);
    check("t3 PIX_READY full", 32'(PIX_READY), 32'd0);
    rd(8'h04, 32'h0006_0040, 1'b0, 0, "t3 STATUS full");
    rd(8'h10, 32'd2, 1'b0, 0, "t3 OVFCNT");
    for (int i = 0; i < DEPTH; i++) rd(8'h00, 32'(i), 1'b0, 1, "t3 drain");
    rd(8'h04, 32'h0005_0000, 1'b0, 0, "t3 STATUS drained");

    // 4: concurrent stream with reads, wrapping the pointers twice
    exp_q.delete();
    fork
      begin : pusher
        for (int i = 0; i < 140; i++) push_word(32'h1000 + 32'(i));
      end
      begin : reader
        logic [31:0] d; logic e; int w; int got; int tries;
        got = 0; tries = 0;
        while (got < 140 && tries < 3000) begin
          apb_xfer(1'b0, 8'h00, 32'd0, d, e, w);
          tries++;
          if (!e) begin
            if (exp_q.size() == 0) check("t4 stream underrun", 32'(exp_q.size()), 32'd1);
            else check("t4 stream data", d, exp_q.pop_front());
            got++;
          end
        end
        check("t4 stream read count", 32'(got), 32'd140);
      end
    join
    check("t4 leftover expected", 32'(exp_q.size()), 32'd0);
    rd(8'h04, 32'h0005_0000, 1'b0, 0, "t4 STATUS");

    // 5: clear with count=10
    for (int i = 0; i < 10; i++) push_word(32'h500 + 32'(i));
    rd(8'h04, 32'h0004_000A, 1'b0, 0, "t5 STATUS before clr");
    wr(8'h08, 32'd3, 1'b0, "t5 CTRL clr");
    exp_q.delete();
    rd(8'h04, 32'h0001_0000, 1'b0, 0, "t5 STATUS after clr");
    rd(8'h10, 32'd0, 1'b0, 0, "t5 OVFCNT after clr");
    rd(8'h08, 32'd1, 1'b0, 0, "t5 CTRL after clr");
    rd(8'h14, 32'd0, 1'b1, 0, "t5 unmapped read");
    wr(8'h04, 32'hFFFF_FFFF, 1'b0, "t5 RO write");
    wr(8'h14, 32'd1, 1'b1, "t5 unmapped write");
    rd(8'h04, 32'h0001_0000, 1'b0, 0, "t5 STATUS after RO write");

    // 6: threshold, interrupt timing, reset during a DATA read
    wr(8'h0C, 32'd4, 1'b0, "t6 THRESH");
    rd(8'h0C, 32'd4, 1'b0, 0, "t6 THRESH rb");
    for (int i = 0; i < 4; i++) push_word(32'h600 + 32'(i));
    @(negedge PCLK);
    check("t6 IRQ same cycle", 32'(IRQ), 32'd0);
    @(negedge PCLK);
`ifdef PIXFIFO_IRQ_EN
    check("t6 IRQ one cycle later", 32'(IRQ), 32'd1);
`else
    check("t6 IRQ tied low", 32'(IRQ), 32'd0);
`endif
    rd(8'h00, 32'h600, 1'b0, 1, "t6 DATA");
    @(negedge PCLK);
    check("t6 IRQ after read", 32'(IRQ), 32'd0);

    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h00;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    check("t6 mid read wait", 32'(PREADY), 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(negedge PCLK);
    check("t6 reset PREADY", 32'(PREADY), 32'd1);
    check("t6 reset PRDATA", PRDATA, 32'd0);
    check("t6 reset PSLVERR", 32'(PSLVERR), 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    exp_q.delete();
    @(negedge PCLK);
    check("t6 PIX_READY after reset", 32'(PIX_READY), 32'd0);
    rd(8'h04, 32'h0001_0000, 1'b0, 0, "t6 STATUS after reset");
    rd(8'h08, 32'd0, 1'b0, 0, "t6 CTRL after reset");
    rd(8'h0C, 32'd0, 1'b0, 0, "t6 THRESH after reset");
    rd(8'h10, 32'd0, 1'b0, 0, "t6 OVFCNT after reset");

    repeat (2) @(posedge PCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
